mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 6, the word-address width of the memory port.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, the data word width.
REQ-003 The module SHALL hold a memory of DEPTH = 2**ADDR_WIDTH words.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port mem_we, input, 1 bit: CPU write enable.
REQ-007 The module SHALL have port mem_addr, input, ADDR_WIDTH bits: CPU word address.
REQ-008 The module SHALL have port mem_data, input, DATA_WIDTH bits: CPU write data.
REQ-009 The module SHALL have port mem_out, output, DATA_WIDTH bits: registered read data, driven to the CPU mem_in.
REQ-010 The module SHALL have port ld_valid, input, 1 bit: loader word valid.
REQ-011 The module SHALL have port ld_data, input, DATA_WIDTH bits: loader word.
REQ-012 The module SHALL have port ld_last, input, 1 bit: marks the final loader word.
REQ-013 The module SHALL have port ld_ready, output, 1 bit: loader word accepted this cycle when high together with ld_valid.
REQ-014 The module SHALL have port cpu_rst_n, output, 1 bit: active-low hold for the CPU, registered.
REQ-015 The module SHALL have port par_err, output, 1 bit: sticky parity error flag.

Function
REQ-016 The module SHALL implement a three-state machine: CLEAR, LOAD, RUN.
REQ-017 In CLEAR, the module SHALL write 0 to one address per cycle, from 0 up to DEPTH-1, then enter LOAD; CLEAR lasts exactly DEPTH cycles.
REQ-018 In LOAD, ld_ready SHALL be 1; ld_ready SHALL be 0 in every other state.
REQ-019 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to the load pointer and increment the pointer; the pointer starts at 0.
REQ-020 The module SHALL leave LOAD for RUN after the handshake carrying ld_last=1, or after the handshake at pointer DEPTH-1, whichever comes first; the pointer SHALL never wrap.
REQ-021 A cycle with ld_valid=0 in LOAD SHALL change no state.
REQ-022 cpu_rst_n SHALL be 0 in CLEAR and LOAD, and SHALL go to 1 on the first clock edge after RUN is entered (one cycle after state becomes RUN).
REQ-023 In RUN, mem_out SHALL be loaded every cycle with mem[mem_addr]: 1-cycle read latency.
REQ-024 In RUN, mem_we=1 SHALL write mem_data to mem[mem_addr] at the clock edge.
REQ-025 Read and write to the same address in the same cycle SHALL be read-first: mem_out returns the old word, and the new word is visible from the next read.
REQ-026 Outside RUN, mem_we, mem_addr and mem_data SHALL be ignored and mem_out SHALL be held at 0.
REQ-027 The module SHALL stay in RUN until reset and SHALL accept no further loader words there.

Reset
REQ-028 On rst_n=0, asynchronously: state=CLEAR, clear pointer=0, load pointer=0, mem_out=0, cpu_rst_n=0, ld_ready=0, par_err=0.
REQ-029 Memory contents SHALL NOT be reset asynchronously; CLEAR zeroes them after reset release.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation, and the full CLEAR, LOAD, RUN sequence SHALL restart.

Configuration
REQ-031 With macro MEM_RESPONDER_PARITY_EN defined, each word SHALL store an extra even-parity bit, written on every CLEAR, LOAD and CPU write.
REQ-032 With MEM_RESPONDER_PARITY_EN defined, every RUN read SHALL check that parity, and a mismatch SHALL set par_err on the same edge that loads mem_out; par_err SHALL clear only on reset.
REQ-033 Without MEM_RESPONDER_PARITY_EN, no parity storage SHALL exist and par_err SHALL be tied to 0.

Verification
REQ-034 Reset release, ld_valid=0 -> ld_ready rises after exactly 64 cycles; cpu_rst_n stays 0.
REQ-035 Load 0x1234, 0xABCD, then 0x0F0F with ld_last=1 -> cpu_rst_n=1 one cycle after the third handshake; RUN reads of addr 0,1,2,3 return 0x1234, 0xABCD, 0x0F0F, 0x0000, each one cycle after the address.
REQ-036 RUN: write 0x5555 to addr 5 with a same-cycle read of addr 5 -> mem_out = old value (0x0000); next-cycle read of addr 5 -> 0x5555.
REQ-037 Load 64 words with ld_last=0 throughout -> RUN is entered after word 63; a 65th ld_valid is not acknowledged; addr 63 reads back word 63.
REQ-038 Assert rst_n=0 after 10 LOAD words, then release -> CLEAR repeats for 64 cycles; addr 3 reads 0 after a short reload.
REQ-039 With MEM_RESPONDER_PARITY_EN defined, the bench forces a flipped stored bit at addr 7, then a read of addr 7 -> par_err=1 and it stays 1; without the macro -> par_err stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory that zeroes itself, takes a loader stream, then serves a CPU port.
// Define MEM_RESPONDER_PARITY_EN to store and check an even-parity bit per word.
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  cpu_rst_n,
  output logic                  par_err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef MEM_RESPONDER_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif
  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr, r_ld_ptr;
  logic [MW-1:0]         r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_out;
  logic                  r_ld_ready, r_cpu_rst_n;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [MW-1:0]         w_word, w_rd;
  // One shared write port: the clear sweep, the loader or the CPU owns it by state.
  always_comb begin
    w_we    = r_state == S_CLEAR ? 1'b1      : r_state == S_LOAD ? ld_valid : mem_we;
    w_waddr = r_state == S_CLEAR ? r_clr_ptr : r_state == S_LOAD ? r_ld_ptr : mem_addr;
    w_wdata = r_state == S_CLEAR ? '0        : r_state == S_LOAD ? ld_data  : mem_data;
`ifdef MEM_RESPONDER_PARITY_EN
    w_word  = {^w_wdata, w_wdata};
`else
    w_word  = w_wdata;
`endif
    w_rd    = r_mem[mem_addr];
  end
  always_ff @(posedge clk) if (w_we) r_mem[w_waddr] <= w_word;
`ifdef MEM_RESPONDER_PARITY_EN
  logic r_par_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err <= 1'b0;
    else if (r_state == S_RUN && ^w_rd) r_par_err <= 1'b1;
  end
  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_clr_ptr   <= '0;
      r_ld_ptr    <= '0;
      r_mem_out   <= '0;
      r_ld_ready  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= r_state == S_RUN;
      r_mem_out   <= r_state == S_RUN ? w_rd[DATA_WIDTH-1:0] : '0;
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (&r_clr_ptr) begin
            r_state    <= S_LOAD;
            r_ld_ready <= 1'b1;
          end
        end
        S_LOAD: if (ld_valid) begin
          if (!(&r_ld_ptr)) r_ld_ptr <= r_ld_ptr + 1'b1;
          if (ld_last || &r_ld_ptr) begin
            r_state    <= S_RUN;
            r_ld_ready <= 1'b0;
          end
        end
        S_RUN: ;
        default: begin
          r_state    <= S_CLEAR;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end
  assign mem_out   = r_mem_out;
  assign ld_ready  = r_ld_ready;
  assign cpu_rst_n = r_cpu_rst_n;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors for clear/load/run sequencing, read-first RAM and parity.
module tb_mem_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_we = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [5:0]  mem_addr = '0;
  logic [15:0] mem_data = '0, ld_data = '0;
  logic [15:0] mem_out;
  logic        ld_ready, cpu_rst_n, par_err;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t v [12];

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_rst_n(cpu_rst_n), .par_err(par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int n, output logic cpu_seen);
    n = 0;
    cpu_seen = 1'b0;
    while (!ld_ready && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      cpu_seen |= cpu_rst_n;
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic last, output logic rdy);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    rdy      = ld_ready;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_vec(input logic we, input logic [5:0] a, input logic [15:0] d,
                         input logic [15:0] exp, input string name);
    mem_we   = we;
    mem_addr = a;
    mem_data = d;
    @(posedge clk);
    @(negedge clk);
    mem_we = 1'b0;
    check(name, mem_out, exp);
  endtask

  initial begin
    int   n;
    logic cs, r, rdy_all;
    v[0]  = '{1'b0, 6'd0,  16'h0000, 16'h1234};
    v[1]  = '{1'b0, 6'd1,  16'h0000, 16'hABCD};
    v[2]  = '{1'b0, 6'd2,  16'h0000, 16'h0F0F};
    v[3]  = '{1'b0, 6'd3,  16'h0000, 16'h0000};
    v[4]  = '{1'b0, 6'd4,  16'h0000, 16'h0000};
    v[5]  = '{1'b1, 6'd5,  16'h5555, 16'h0000};
    v[6]  = '{1'b0, 6'd5,  16'h0000, 16'h5555};
    v[7]  = '{1'b1, 6'd0,  16'hBEEF, 16'h1234};
    v[8]  = '{1'b0, 6'd0,  16'h0000, 16'hBEEF};
    v[9]  = '{1'b0, 6'd63, 16'h0000, 16'h0000};
    v[10] = '{1'b1, 6'd63, 16'hC0DE, 16'h0000};
    v[11] = '{1'b0, 6'd63, 16'h0000, 16'hC0DE};

    repeat (2) @(negedge clk);
    check("rst mem_out", mem_out, 0);
    check("rst cpu_rst_n", cpu_rst_n, 0);
    check("rst ld_ready", ld_ready, 0);
    check("rst par_err", par_err, 0);

    rst_n = 1'b1;
    mem_we = 1'b1; mem_addr = 6'd4; mem_data = 16'hFFFF;
    wait_ready(n, cs);
    check("clear cycles", n, 64);
    check("cpu held in clear", cs, 0);
    check("mem_out held in load", mem_out, 0);
    load_word(16'h1234, 1'b0, r);
    check("ready word0", r, 1);
    ld_data = 16'hDEAD;
    repeat (3) @(negedge clk);
    check("ready idle", ld_ready, 1);
    load_word(16'hABCD, 1'b0, r);
    mem_we = 1'b0; mem_addr = 6'd0;
    load_word(16'h0F0F, 1'b1, r);
    check("ready word2", r, 1);
    check("cpu_rst_n at run entry", cpu_rst_n, 0);
    check("ready in run", ld_ready, 0);
    for (int i = 0; i < 12; i++) begin
      run_vec(v[i].we, v[i].addr, v[i].data, v[i].exp, $sformatf("vec%0d", i));
      if (i == 0) check("cpu_rst_n after run", cpu_rst_n, 1);
    end

`ifdef MEM_RESPONDER_PARITY_EN
    check("par clean", par_err, 0);
    dut.r_mem[7][0] = ~dut.r_mem[7][0];
    run_vec(1'b0, 6'd7, 16'h0, 16'h0001, "par flipped read");
    check("par set", par_err, 1);
    run_vec(1'b0, 6'd0, 16'h0, 16'hBEEF, "par after read");
    check("par sticky", par_err, 1);
`else
    run_vec(1'b0, 6'd7, 16'h0, 16'h0000, "read addr7");
    check("par tied", par_err, 0);
    run_vec(1'b0, 6'd0, 16'h0, 16'hBEEF, "read addr0");
    check("par tied2", par_err, 0);
`endif

    rst_n = 1'b0;
    #1;
    check("run rst mem_out", mem_out, 0);
    check("run rst cpu_rst_n", cpu_rst_n, 0);
    check("run rst par_err", par_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, cs);
    check("clear cycles 2", n, 64);
    rdy_all = 1'b1;
    for (int i = 0; i < 64; i++) begin
      load_word(16'(16'h1000 + i), 1'b0, r);
      rdy_all &= r;
    end
    check("ready all 64", rdy_all, 1);
    check("ready after 64", ld_ready, 0);
    load_word(16'hDEAD, 1'b0, r);
    check("word65 not acked", r, 0);
    check("cpu_rst_n full load", cpu_rst_n, 1);
    run_vec(1'b0, 6'd63, 16'h0, 16'h103F, "full addr63");
    run_vec(1'b0, 6'd0,  16'h0, 16'h1000, "full addr0");
    run_vec(1'b0, 6'd62, 16'h0, 16'h103E, "full addr62");

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, cs);
    for (int i = 0; i < 10; i++) load_word(16'(16'hA000 + i), 1'b0, r);
    rst_n = 1'b0;
    #1;
    check("load rst ready", ld_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, cs);
    check("clear cycles 3", n, 64);
    check("cpu held 3", cs, 0);
    load_word(16'h1111, 1'b0, r);
    load_word(16'h2222, 1'b1, r);
    run_vec(1'b0, 6'd3, 16'h0, 16'h0000, "reload addr3");
    run_vec(1'b0, 6'd1, 16'h0, 16'h2222, "reload addr1");
    run_vec(1'b0, 6'd9, 16'h0, 16'h0000, "reload addr9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
